// File: rtl/cr16_pkg.sv
// Shared types and encodings for the CR16-subset multicycle control unit.
// Opcode fields are {inst[15:12], inst[7:4]}; PSR is {C,L,F,Z,N}.
package cr16_pkg;

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_LATCH = 3'd1,
        S_EXEC  = 3'd2,
        S_MEM   = 3'd3,
        S_LDWB  = 3'd4
    } state_t;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_MOV = 4'd5;
    localparam logic [3:0] ALU_LSH = 4'd6;
    localparam logic [3:0] ALU_LUI = 4'd7;

    localparam logic [7:0] OP_ADD   = 8'b0000_0101;
    localparam logic [7:0] OP_SUB   = 8'b0000_1001;
    localparam logic [7:0] OP_CMP   = 8'b0000_1011;
    localparam logic [7:0] OP_AND   = 8'b0000_0001;
    localparam logic [7:0] OP_OR    = 8'b0000_0010;
    localparam logic [7:0] OP_XOR   = 8'b0000_0011;
    localparam logic [7:0] OP_MOV   = 8'b0000_1101;
    localparam logic [7:0] OP_LSH   = 8'b1000_0100;
    localparam logic [7:0] OP_LOAD  = 8'b0100_0000;
    localparam logic [7:0] OP_STOR  = 8'b0100_0100;
    localparam logic [7:0] OP_JAL   = 8'b0100_1000;
    localparam logic [7:0] OP_JCOND = 8'b0100_1100;

    // Upper-nibble classes; immediate forms carry imm[7:4] in the low nibble
    localparam logic [3:0] OPH_RR    = 4'b0000;
    localparam logic [3:0] OPH_ANDI  = 4'b0001;
    localparam logic [3:0] OPH_ORI   = 4'b0010;
    localparam logic [3:0] OPH_XORI  = 4'b0011;
    localparam logic [3:0] OPH_ADDI  = 4'b0101;
    localparam logic [3:0] OPH_SHIFT = 4'b1000;
    localparam logic [3:0] OPH_SUBI  = 4'b1001;
    localparam logic [3:0] OPH_CMPI  = 4'b1011;
    localparam logic [3:0] OPH_BCOND = 4'b1100;
    localparam logic [3:0] OPH_MOVI  = 4'b1101;
    localparam logic [3:0] OPH_LUI   = 4'b1111;

    localparam logic [3:0] CC_EQ = 4'b0000;
    localparam logic [3:0] CC_NE = 4'b0001;
    localparam logic [3:0] CC_CS = 4'b0010;
    localparam logic [3:0] CC_CC = 4'b0011;
    localparam logic [3:0] CC_HI = 4'b0100;
    localparam logic [3:0] CC_LS = 4'b0101;
    localparam logic [3:0] CC_GT = 4'b0110;
    localparam logic [3:0] CC_LE = 4'b0111;
    localparam logic [3:0] CC_FS = 4'b1000;
    localparam logic [3:0] CC_FC = 4'b1001;
    localparam logic [3:0] CC_LO = 4'b1010;
    localparam logic [3:0] CC_HS = 4'b1011;
    localparam logic [3:0] CC_LT = 4'b1100;
    localparam logic [3:0] CC_GE = 4'b1101;
    localparam logic [3:0] CC_UC = 4'b1110;
    localparam logic [3:0] CC_NV = 4'b1111;

    localparam logic [1:0] PC_INC  = 2'b00;
    localparam logic [1:0] PC_DISP = 2'b01;
    localparam logic [1:0] PC_REG  = 2'b10;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_MEM  = 2'b01;
    localparam logic [1:0] WB_LINK = 2'b10;

    localparam int PSR_C = 4;
    localparam int PSR_L = 3;
    localparam int PSR_F = 2;
    localparam int PSR_Z = 1;
    localparam int PSR_N = 0;

endpackage

// File: rtl/cr16_cond_eval.sv
// Branch/jump condition evaluator: condition code against held PSR.
module cr16_cond_eval
    import cr16_pkg::*;
(
    input  logic [3:0] i_cond,
    input  logic [4:0] i_psr,
    output logic       o_take
);

    logic w_c, w_l, w_f, w_z, w_n;

    assign w_c = i_psr[PSR_C];
    assign w_l = i_psr[PSR_L];
    assign w_f = i_psr[PSR_F];
    assign w_z = i_psr[PSR_Z];
    assign w_n = i_psr[PSR_N];

    always_comb begin
        o_take = 1'b0;
        case (i_cond)
            CC_EQ:   o_take = w_z;
            CC_NE:   o_take = !w_z;
            CC_CS:   o_take = w_c;
            CC_CC:   o_take = !w_c;
            CC_HI:   o_take = w_l;
            CC_LS:   o_take = !w_l;
            CC_GT:   o_take = w_n;
            CC_LE:   o_take = !w_n;
            CC_FS:   o_take = w_f;
            CC_FC:   o_take = !w_f;
            CC_LO:   o_take = !w_l && !w_z;
            CC_HS:   o_take = w_l || w_z;
            CC_LT:   o_take = !w_n && !w_z;
            CC_GE:   o_take = w_n || w_z;
            CC_UC:   o_take = 1'b1;
            default: o_take = 1'b0;
        endcase
    end

endmodule

// File: rtl/cr16_ctrl_fsm.sv
// CR16-subset multicycle controller: FETCH/LATCH/EXEC/MEM/LDWB plus PSR.
// Define CR16_JAL_EN to decode JAL; otherwise JAL raises illegal.
module cr16_ctrl_fsm
    import cr16_pkg::*;
#(
    parameter logic [2:0] RESET_STATE = 3'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] opcode,
    input  logic [3:0] rdst,
    input  logic [3:0] rsrc,
    input  logic [4:0] alu_flags,
    output logic       ir_en,
    output logic       pc_en,
    output logic [1:0] pc_sel,
    output logic       addr_sel,
    output logic       mem_we,
    output logic       reg_we,
    output logic [1:0] wb_sel,
    output logic [3:0] alu_op,
    output logic       alu_b_imm,
    output logic       imm_sext,
    output logic [4:0] psr,
    output logic       illegal
);

    state_t     r_state;
    state_t     w_next;
    logic [4:0] r_psr;
    logic       w_take;
    logic       w_alu, w_imm, w_sx, w_cmp, w_fl;
    logic [3:0] w_op;
    logic       w_unused;

    // rsrc steers the datapath only
    assign w_unused = ^rsrc;
    assign psr      = r_psr;

    cr16_cond_eval u_cond (
        .i_cond (rdst),
        .i_psr  (r_psr),
        .o_take (w_take)
    );

    always_comb begin
        w_alu = 1'b1;
        w_imm = 1'b0;
        w_sx  = 1'b0;
        w_cmp = 1'b0;
        w_fl  = 1'b0;
        w_op  = ALU_ADD;
        case (opcode[7:4])
            OPH_RR: begin
                case (opcode)
                    OP_ADD:  w_fl = 1'b1;
                    OP_SUB:  begin w_op = ALU_SUB; w_fl = 1'b1; end
                    OP_CMP:  begin w_op = ALU_SUB; w_fl = 1'b1; w_cmp = 1'b1; end
                    OP_AND:  w_op = ALU_AND;
                    OP_OR:   w_op = ALU_OR;
                    OP_XOR:  w_op = ALU_XOR;
                    OP_MOV:  w_op = ALU_MOV;
                    default: w_alu = 1'b0;
                endcase
            end
            OPH_ADDI: begin w_imm = 1'b1; w_sx = 1'b1; w_fl = 1'b1; end
            OPH_SUBI: begin w_op = ALU_SUB; w_imm = 1'b1; w_sx = 1'b1; w_fl = 1'b1; end
            OPH_CMPI: begin
                w_op  = ALU_SUB;
                w_imm = 1'b1;
                w_sx  = 1'b1;
                w_fl  = 1'b1;
                w_cmp = 1'b1;
            end
            OPH_ANDI: begin w_op = ALU_AND; w_imm = 1'b1; end
            OPH_ORI:  begin w_op = ALU_OR;  w_imm = 1'b1; end
            OPH_XORI: begin w_op = ALU_XOR; w_imm = 1'b1; end
            OPH_MOVI: begin w_op = ALU_MOV; w_imm = 1'b1; end
            OPH_LUI:  begin w_op = ALU_LUI; w_imm = 1'b1; end
            // LSH is 1000_0100; LSHI is 1000_000s with s the shift direction
            OPH_SHIFT: begin
                w_op = ALU_LSH;
                if (opcode == OP_LSH) w_imm = 1'b0;
                else if (opcode[3:1] == 3'b000) w_imm = 1'b1;
                else w_alu = 1'b0;
            end
            default: w_alu = 1'b0;
        endcase
    end

    always_comb begin
        ir_en     = 1'b0;
        pc_en     = 1'b0;
        pc_sel    = PC_INC;
        addr_sel  = 1'b0;
        mem_we    = 1'b0;
        reg_we    = 1'b0;
        wb_sel    = WB_ALU;
        alu_op    = ALU_ADD;
        alu_b_imm = 1'b0;
        imm_sext  = 1'b0;
        illegal   = 1'b0;
        w_next    = S_FETCH;
        case (r_state)
            S_FETCH: w_next = S_LATCH;
            S_LATCH: begin
                ir_en  = 1'b1;
                w_next = S_EXEC;
            end
            S_EXEC: begin
                pc_en = 1'b1;
                if (opcode == OP_LOAD || opcode == OP_STOR) begin
                    pc_en  = 1'b0;
                    w_next = S_MEM;
                end else if (opcode == OP_JCOND) begin
                    pc_sel = w_take ? PC_REG : PC_INC;
                end else if (opcode[7:4] == OPH_BCOND) begin
                    pc_sel = w_take ? PC_DISP : PC_INC;
`ifdef CR16_JAL_EN
                end else if (opcode == OP_JAL) begin
                    reg_we = 1'b1;
                    wb_sel = WB_LINK;
                    pc_sel = PC_REG;
`endif
                end else if (w_alu) begin
                    reg_we    = !w_cmp;
                    alu_op    = w_op;
                    alu_b_imm = w_imm;
                    imm_sext  = w_sx;
                end else begin
                    illegal = 1'b1;
                end
            end
            S_MEM: begin
                addr_sel = 1'b1;
                if (opcode == OP_STOR) begin
                    mem_we = 1'b1;
                    pc_en  = 1'b1;
                end else if (opcode == OP_LOAD) begin
                    w_next = S_LDWB;
                end
            end
            S_LDWB: begin
                reg_we = 1'b1;
                wb_sel = WB_MEM;
                pc_en  = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= state_t'(RESET_STATE);
            r_psr   <= 5'd0;
        end else begin
            r_state <= w_next;
            if (r_state == S_EXEC && w_alu && w_fl)
                r_psr <= alu_flags;
        end
    end

endmodule

// File: tb/tb_cr16_ctrl_fsm.sv
// Directed bench for cr16_ctrl_fsm; outputs sampled 1ns after posedge.
// Build with CR16_JAL_EN defined to expect JAL decoding.
module tb_cr16_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] opcode = 8'd0;
    logic [3:0] rdst = 4'd0;
    logic [3:0] rsrc = 4'd0;
    logic [4:0] alu_flags = 5'd0;
    logic       ir_en, pc_en, addr_sel, mem_we, reg_we;
    logic       alu_b_imm, imm_sext, illegal;
    logic [1:0] pc_sel, wb_sel;
    logic [3:0] alu_op;
    logic [4:0] psr;

    int errs = 0;
    int chks = 0;
    logic [15:0] e;

    always #5 clk = ~clk;

    cr16_ctrl_fsm dut (
        .clk       (clk),
        .rst       (rst),
        .opcode    (opcode),
        .rdst      (rdst),
        .rsrc      (rsrc),
        .alu_flags (alu_flags),
        .ir_en     (ir_en),
        .pc_en     (pc_en),
        .pc_sel    (pc_sel),
        .addr_sel  (addr_sel),
        .mem_we    (mem_we),
        .reg_we    (reg_we),
        .wb_sel    (wb_sel),
        .alu_op    (alu_op),
        .alu_b_imm (alu_b_imm),
        .imm_sext  (imm_sext),
        .psr       (psr),
        .illegal   (illegal)
    );

    wire [15:0] w_out = {ir_en, pc_en, pc_sel, addr_sel, mem_we, reg_we,
                         wb_sel, alu_op, alu_b_imm, imm_sext, illegal};

    function automatic logic [15:0] pk(
        input logic ir, pe, input logic [1:0] ps, input logic as, we, rw,
        input logic [1:0] wb, input logic [3:0] op, input logic bi, sx, il);
        return {ir, pe, ps, as, we, rw, wb, op, bi, sx, il};
    endfunction

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    // from FETCH: present the instruction, land in EXEC
    task automatic go_exec(input logic [7:0] op, input logic [3:0] rd,
                           input logic [4:0] fl);
        opcode = op;
        rdst = rd;
        alu_flags = fl;
        cyc();
        cyc();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        opcode = 8'h00;
        cyc();
        cyc();
        if ({w_out, psr} !== 21'd0) begin
            errs++; $display("FAIL reset_out out=%h psr=%b exp=0", w_out, psr);
        end
        chks++;
        rst = 1'b0;
        if (w_out !== 16'd0) begin
            errs++; $display("FAIL fetch_idle out=%h exp=0", w_out);
        end
        chks++;
        cyc();
        e = pk(1, 0, 2'b00, 0, 0, 0, 2'b00, 4'd0, 0, 0, 0);
        if (w_out !== e) begin
            errs++; $display("FAIL latch_ir_en out=%h exp=%h", w_out, e);
        end
        chks++;
        cyc();
        e = pk(0, 1, 2'b00, 0, 0, 0, 2'b00, 4'd0, 0, 0, 1);
        if (w_out !== e) begin
            errs++; $display("FAIL exec_nop out=%h exp=%h", w_out, e);
        end
        chks++;
        cyc();
        if (psr !== 5'd0) begin
            errs++; $display("FAIL nop_psr psr=%b exp=00000", psr);
        end
        chks++;
    endtask

    task automatic test_add;
        go_exec(8'h05, 4'd3, 5'b00010);
        e = pk(0, 1, 2'b00, 0, 0, 1, 2'b00, 4'd0, 0, 0, 0);
        if (w_out !== e || psr !== 5'd0) begin
            errs++; $display("FAIL add_exec out=%h psr=%b exp=%h/00000", w_out, psr, e);
        end
        chks++;
        cyc();
        if (psr !== 5'b00010 || w_out !== 16'd0) begin
            errs++; $display("FAIL add_psr psr=%b out=%h exp=00010/0", psr, w_out);
        end
        chks++;
    endtask

    task automatic test_bcond;
        go_exec(8'hC0, 4'h0, 5'd0);
        e = pk(0, 1, 2'b01, 0, 0, 0, 2'b00, 4'd0, 0, 0, 0);
        if (w_out !== e) begin
            errs++; $display("FAIL beq_taken out=%h exp=%h", w_out, e);
        end
        chks++;
        cyc();
        go_exec(8'h0B, 4'd5, 5'd0);
        e = pk(0, 1, 2'b00, 0, 0, 0, 2'b00, 4'd1, 0, 0, 0);
        if (w_out !== e) begin
            errs++; $display("FAIL cmp_exec out=%h exp=%h", w_out, e);
        end
        chks++;
        cyc();
        if (psr !== 5'd0) begin
            errs++; $display("FAIL cmp_psr psr=%b exp=00000", psr);
        end
        chks++;
        go_exec(8'hC0, 4'h0, 5'd0);
        e = pk(0, 1, 2'b00, 0, 0, 0, 2'b00, 4'd0, 0, 0, 0);
        if (w_out !== e) begin
            errs++; $display("FAIL beq_not out=%h exp=%h", w_out, e);
        end
        chks++;
        cyc();
        go_exec(8'hC3, 4'hE, 5'd0);
        e = pk(0, 1, 2'b01, 0, 0, 0, 2'b00, 4'd0, 0, 0, 0);
        if (w_out !== e) begin
            errs++; $display("FAIL buc_taken out=%h exp=%h", w_out, e);
        end
        chks++;
        cyc();
        go_exec(8'hC3, 4'hF, 5'd0);
        e = pk(0, 1, 2'b00, 0, 0, 0, 2'b00, 4'd0, 0, 0, 0);
        if (w_out !== e) begin
            errs++; $display("FAIL bnever out=%h exp=%h", w_out, e);
        end
        chks++;
        cyc();
    endtask

    task automatic test_jcond;
        go_exec(8'h93, 4'd2, 5'b01001);
        e = pk(0, 1, 2'b00, 0, 0, 1, 2'b00, 4'd1, 1, 1, 0);
        if (w_out !== e) begin
            errs++; $display("FAIL subi_exec out=%h exp=%h", w_out, e);
        end
        chks++;
        cyc();
        if (psr !== 5'b01001) begin
            errs++; $display("FAIL subi_psr psr=%b exp=01001", psr);
        end
        chks++;
        go_exec(8'h4C, 4'h4, 5'd0);
        e = pk(0, 1, 2'b10, 0, 0, 0, 2'b00, 4'd0, 0, 0, 0);
        if (w_out !== e) begin
            errs++; $display("FAIL jhi_taken out=%h exp=%h", w_out, e);
        end
        chks++;
        cyc();
        go_exec(8'h4C, 4'hA, 5'd0);
        e = pk(0, 1, 2'b00, 0, 0, 0, 2'b00, 4'd0, 0, 0, 0);
        if (w_out !== e) begin
            errs++; $display("FAIL jlo_not out=%h exp=%h", w_out, e);
        end
        chks++;
        cyc();
        go_exec(8'h4C, 4'hD, 5'd0);
        e = pk(0, 1, 2'b10, 0, 0, 0, 2'b00, 4'd0, 0, 0, 0);
        if (w_out !== e) begin
            errs++; $display("FAIL jge_taken out=%h exp=%h", w_out, e);
        end
        chks++;
        cyc();
    endtask

    task automatic test_alu_imm;
        go_exec(8'h17, 4'd1, 5'b11111);
        e = pk(0, 1, 2'b00, 0, 0, 1, 2'b00, 4'd2, 1, 0, 0);
        if (w_out !== e) begin
            errs++; $display("FAIL andi_exec out=%h exp=%h", w_out, e);
        end
        chks++;
        cyc();
        if (psr !== 5'b01001) begin
            errs++; $display("FAIL andi_psr_hold psr=%b exp=01001", psr);
        end
        chks++;
        go_exec(8'h81, 4'd1, 5'd0);
        e = pk(0, 1, 2'b00, 0, 0, 1, 2'b00, 4'd6, 1, 0, 0);
        if (w_out !== e) begin
            errs++; $display("FAIL lshi_exec out=%h exp=%h", w_out, e);
        end
        chks++;
        cyc();
        go_exec(8'hF5, 4'd1, 5'd0);
        e = pk(0, 1, 2'b00, 0, 0, 1, 2'b00, 4'd7, 1, 0, 0);
        if (w_out !== e) begin
            errs++; $display("FAIL lui_exec out=%h exp=%h", w_out, e);
        end
        chks++;
        cyc();
    endtask

    task automatic test_load;
        rsrc = 4'd5;
        go_exec(8'h40, 4'd2, 5'd0);
        if (w_out !== 16'd0) begin
            errs++; $display("FAIL load_exec out=%h exp=0", w_out);
        end
        chks++;
        cyc();
        e = pk(0, 0, 2'b00, 1, 0, 0, 2'b00, 4'd0, 0, 0, 0);
        if (w_out !== e) begin
            errs++; $display("FAIL load_mem out=%h exp=%h", w_out, e);
        end
        chks++;
        cyc();
        e = pk(0, 1, 2'b00, 0, 0, 1, 2'b01, 4'd0, 0, 0, 0);
        if (w_out !== e) begin
            errs++; $display("FAIL load_wb out=%h exp=%h", w_out, e);
        end
        chks++;
        cyc();
        if (w_out !== 16'd0) begin
            errs++; $display("FAIL load_fetch out=%h exp=0", w_out);
        end
        chks++;
    endtask

    task automatic test_stor_reset;
        go_exec(8'h44, 4'd0, 5'd0);
        if (w_out !== 16'd0) begin
            errs++; $display("FAIL stor_exec out=%h exp=0", w_out);
        end
        chks++;
        cyc();
        e = pk(0, 1, 2'b00, 1, 1, 0, 2'b00, 4'd0, 0, 0, 0);
        if (w_out !== e) begin
            errs++; $display("FAIL stor_mem out=%h exp=%h", w_out, e);
        end
        chks++;
        cyc();
        if (w_out !== 16'd0) begin
            errs++; $display("FAIL stor_fetch out=%h exp=0", w_out);
        end
        chks++;
        go_exec(8'h44, 4'd0, 5'd0);
        cyc();
        if (mem_we !== 1'b1) begin
            errs++; $display("FAIL stor2_mem_we got=%b exp=1", mem_we);
        end
        chks++;
        rst = 1'b1;
        cyc();
        if ({w_out, psr} !== 21'd0) begin
            errs++; $display("FAIL stor_rst out=%h psr=%b exp=0", w_out, psr);
        end
        chks++;
        rst = 1'b0;
        opcode = 8'h00;
        cyc();
        e = pk(1, 0, 2'b00, 0, 0, 0, 2'b00, 4'd0, 0, 0, 0);
        if (w_out !== e) begin
            errs++; $display("FAIL stor_rst_latch out=%h exp=%h", w_out, e);
        end
        chks++;
        cyc();
        cyc();
    endtask

    task automatic test_jal;
        rsrc = 4'd7;
        go_exec(8'h48, 4'd2, 5'd0);
`ifdef CR16_JAL_EN
        e = pk(0, 1, 2'b10, 0, 0, 1, 2'b10, 4'd0, 0, 0, 0);
`else
        e = pk(0, 1, 2'b00, 0, 0, 0, 2'b00, 4'd0, 0, 0, 1);
`endif
        if (w_out !== e) begin
            errs++; $display("FAIL jal_exec out=%h exp=%h", w_out, e);
        end
        chks++;
        cyc();
        if (w_out !== 16'd0) begin
            errs++; $display("FAIL jal_fetch out=%h exp=0", w_out);
        end
        chks++;
    endtask

    initial begin
        test_reset();
        test_add();
        test_bcond();
        test_jcond();
        test_alu_imm();
        test_load();
        test_stor_reset();
        test_jal();
        $display("Result: errors=%0d of %0d checks", errs, chks);
        $finish;
    end

endmodule

// File: doc/cr16_ctrl_fsm.md
Name: cr16_ctrl_fsm

Overview:
- Multicycle control unit for the CR16-subset datapath. Sits directly downstream of the instruction register.
- Consumes the decoded fields (8-bit opcode, Rdst, Rsrc) and drives the IR load enable back upstream.
- Sequences fetch/execute/memory/writeback, generates datapath selects, and holds the PSR flags used for conditional branches and jumps.

Parameters:
- RESET_STATE, 0, encoding of the state entered on reset (FETCH).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- opcode  in  8  {inst[15:12], inst[7:4]} from IR
- rdst  in  4  Rdst / condition field from IR
- rsrc  in  4  Rsrc / Raddr / Rtarget field from IR
- alu_flags  in  5  {C,L,F,Z,N} computed by ALU this cycle
- ir_en  out  1  IR load enable
- pc_en  out  1  PC update enable
- pc_sel  out  2  00 PC+1, 01 PC+sext(disp), 10 Rsrc value
- addr_sel  out  1  0 memory address=PC, 1 memory address=Rsrc value
- mem_we  out  1  data memory write strobe
- reg_we  out  1  register file write enable (dest=rdst)
- wb_sel  out  2  00 ALU, 01 memory data, 10 PC+1
- alu_op  out  4  ALU function code (package constants)
- alu_b_imm  out  1  ALU B operand: 0 register, 1 immediate
- imm_sext  out  1  immediate extension: 1 sign, 0 zero
- psr  out  5  current flag register {C,L,F,Z,N}
- illegal  out  1  pulses one cycle in EXEC on an undecodable opcode

Behaviour:
- States:
  - FETCH(0): addr_sel=0. Unconditionally goes to LATCH.
  - LATCH(1): addr_sel=0, ir_en=1. Goes to EXEC.
  - EXEC(2): decodes opcode.
  - MEM(3): addr_sel=1.
  - LDWB(4): load writeback.
- All outputs are Moore/decoded-in-state. Every output not listed for a state is 0.
- EXEC, ALU ops (ADD/ADDI/SUB/SUBI/CMP/CMPI/AND/ANDI/OR/ORI/XOR/XORI/MOV/MOVI/LSH/LSHI/LUI):
  - reg_we=1 except CMP/CMPI; pc_en=1, pc_sel=00; goes to FETCH.
  - psr updates from alu_flags on ADD*/SUB*/CMP* only.
  - Immediate forms: alu_b_imm=1; imm_sext=1 for ADDI/SUBI/CMPI, else 0.
- EXEC, Bcond (opcode[7:4]=1100): pc_en=1, pc_sel=01 if the condition on rdst is true, else 00. Goes to FETCH.
- EXEC, Jcond (opcode=0100_1100): pc_en=1, pc_sel=10 if the condition is true, else 00. Goes to FETCH.
- EXEC, LOAD (0100_0000) or STOR (0100_0100): no PC update. Goes to MEM.
- MEM:
  - STOR: mem_we=1, pc_en=1, pc_sel=00; goes to FETCH.
  - LOAD: goes to LDWB.
- LDWB: reg_we=1, wb_sel=01, pc_en=1, pc_sel=00. Goes to FETCH.
- Instruction latency: ALU/branch 3 cycles, STOR 4, LOAD 5.
- Conditions are evaluated on psr held from before this instruction:
  - EQ 0000 Z; NE 0001 !Z; CS 0010 C; CC 0011 !C; HI 0100 L; LS 0101 !L
  - GT 0110 N; LE 0111 !N; FS 1000 F; FC 1001 !F; LO 1010 !L&!Z; HS 1011 L|Z
  - LT 1100 !N&!Z; GE 1101 N|Z; UC 1110 always; 1111 never
- Undecodable opcode in EXEC: illegal=1, pc_en=1, pc_sel=00 (treated as NOP). Goes to FETCH.
- Reset: state=FETCH, psr=0, all outputs 0. rst in any state (including MEM with mem_we high) forces FETCH next edge; mem_we is 0 in the reset cycle's output since it is decoded from state.
- Unused state encodings return to FETCH.

Optional Feature:
- Macro CR16_JAL_EN.
- Defined: JAL (opcode 0100_1000) in EXEC sets reg_we=1, wb_sel=10 (link = PC+1 into rdst), pc_en=1, pc_sel=10. Goes to FETCH.
- Undefined: JAL is undecodable, so it raises illegal and executes as a NOP.

Decomposition:
- Package cr16_pkg holds:
  - state enum;
  - alu_op codes: ADD, SUB, AND, OR, XOR, MOV, LSH, LUI;
  - opcode constants;
  - condition-code constants;
  - pc_sel/wb_sel encodings;
  - PSR bit indices.
- Sub-module cr16_cond_eval: combinational (cond[3:0], psr[4:0]) -> take.

Test Plan:
- Reset then idle: rst held 2 cycles -> state FETCH, psr=0, all outputs 0. Then observe ir_en=1 in cycle 2 after release and EXEC in cycle 3.
- ADD (opcode 0000_0101, rdst=3), alu_flags=5'b00010 -> EXEC: reg_we=1, alu_b_imm=0, pc_sel=00, pc_en=1; psr=00010 after the edge. Next state FETCH.
- BEQ (1100, rdst=0000) with psr.Z=1 -> pc_sel=01. Repeat with Z=0 -> pc_sel=00. UC taken, 1111 not taken.
- LOAD (0100_0000, rsrc=5) -> EXEC (no pc_en), MEM addr_sel=1, then LDWB reg_we=1 wb_sel=01 pc_en=1. 5 cycles total.
- STOR (0100_0100) with rst asserted during MEM -> next state FETCH. mem_we is 0 from the reset cycle onward, and no pc_en.
- Opcode 0100_1000: with CR16_JAL_EN, reg_we=1, wb_sel=10, pc_sel=10. Without it, illegal=1 and pc_sel=00.
